proyecto3_system_onchip_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port on-chip memory (16384 x 32-bit words, byte enables, registered address/unregistered read data) between two Avalon-MM style masters in the proyecto3 system. It grants one request per cycle, forwards the winner's command to the memory, and steers read data back to the owner one cycle later. It sits between the interconnect master ports and the on-chip memory slave.

---
 rtl/proyecto3_onchip_pkg.sv | 14 +
 rtl/proyecto3_onchip_rr_grant.sv | 68 ++++++
 rtl/proyecto3_system_onchip_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_proyecto3_system_onchip_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proyecto3_onchip_pkg.sv
// Shared definitions for the proyecto3 on-chip memory arbiter:
// default widths, the default burst limit and the master index type.
package proyecto3_onchip_pkg;

    localparam int ADDR_W_DEF    = 14;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage

// File: rtl/proyecto3_onchip_rr_grant.sv
// Two-way round-robin grant with a burst limit.
// Used only when PROYECTO3_ONCHIP_ARB_RR_EN is defined.
// The current owner keeps the grant under contention while it has been
// granted fewer than MAX_BURST consecutive cycles. An idle cycle ends
// ownership, so the next tie goes to the master not granted last.
module proyecto3_onchip_rr_grant
    import proyecto3_onchip_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    master_e    last_grant_q, last_grant_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    master_e    win;
    logic       keep;

    // Pick the winner from the requests and the burst history.
    always_comb begin
        keep        = (burst_cnt_q != 8'd0) && (burst_cnt_q < MAX_BURST_C);
        gnt_valid_o = req0_i | req1_i;
        win         = M0;
        if (req0_i && req1_i) begin
            if (keep) begin
                win = last_grant_q;
            end else begin
                win = (last_grant_q == M0) ? M1 : M0;
            end
        end else if (req1_i) begin
            win = M1;
        end
        gnt_idx_o = win;
    end

    // Update owner and consecutive-grant count; saturate at 255.
    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (!gnt_valid_o) begin
            burst_cnt_d = 8'd0;
        end else if (win != last_grant_q) begin
            last_grant_d = win;
            burst_cnt_d  = 8'd1;
        end else if (burst_cnt_q != 8'hFF) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    // History registers; m0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= M1;
            burst_cnt_q  <= 8'd0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/proyecto3_system_onchip_mem_arbiter.sv
// Two-master arbiter in front of the single-port on-chip memory.
// One request is granted per cycle; its command drives the memory and the
// read data comes back to the owner one cycle later.
// Configuration macro: PROYECTO3_ONCHIP_ARB_RR_EN
//   defined   -> round-robin with MAX_BURST limit (proyecto3_onchip_rr_grant)
//   undefined -> fixed priority, m0 always wins contention
// Handshake: a master holds mX_read/mX_write with its command; the command is
// accepted in the cycle where mX_waitrequest is 0. A read accepted at edge N
// returns data with mX_readdatavalid=1 in the cycle after N.
module proyecto3_system_onchip_mem_arbiter
    import proyecto3_onchip_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..255");
    end

    logic    req0_raw, req1_raw;
    logic    req0, req1;
    logic    gnt_valid;
    master_e win;
    logic    win_read, win_write;
    logic    rd_pend_q, rd_pend_d;
    master_e rd_owner_q, rd_owner_d;

    // Nothing is granted while reset is held.
    assign req0_raw = m0_read | m0_write;
    assign req1_raw = m1_read | m1_write;
    assign req0     = req0_raw & ~reset;
    assign req1     = req1_raw & ~reset;

`ifdef PROYECTO3_ONCHIP_ARB_RR_EN
    logic gnt_idx;

    proyecto3_onchip_rr_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_grant (
        .clk         (clk),
        .reset       (reset),
        .req0_i      (req0),
        .req1_i      (req1),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign win = master_e'(gnt_idx);
`else
    assign gnt_valid = req0 | req1;
    assign win       = req0 ? M0 : M1;
`endif

    assign m0_waitrequest = req0_raw & ~(gnt_valid & (win == M0));
    assign m1_waitrequest = req1_raw & ~(gnt_valid & (win == M1));

    // Steer the winner's command to the memory; m0 values when idle.
    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        win_read       = m0_read;
        win_write      = m0_write;
        if (gnt_valid && (win == M1)) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            win_read       = m1_read;
            win_write      = m1_write;
        end
        mem_chipselect = gnt_valid;
        mem_write      = gnt_valid & win_write;
    end

    assign mem_clken = 1'b1;

    // A granted read (write wins if both are set) returns next cycle.
    always_comb begin
        rd_pend_d  = gnt_valid & win_read & ~win_write;
        rd_owner_d = rd_pend_d ? win : rd_owner_q;
    end

    // Read-return tracking; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= M0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Reset also masks a response already on the wire this cycle.
    assign m0_readdatavalid = rd_pend_q & ~reset & (rd_owner_q == M0);
    assign m1_readdatavalid = rd_pend_q & ~reset & (rd_owner_q == M1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    a_m0_rw_excl : assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
    a_m1_rw_excl : assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_proyecto3_system_onchip_mem_arbiter.sv
// Testbench for proyecto3_system_onchip_mem_arbiter (either value of
// PROYECTO3_ONCHIP_ARB_RR_EN). The bench owns a memory model with registered
// address, a behavioural arbitration model based on grant history, and a
// reference memory that predicts every read response.
module tb_proyecto3_system_onchip_mem_arbiter;
  import proyecto3_onchip_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int BW = DW / 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, mem_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          mem_chipselect, mem_write, mem_clken;

  proyecto3_system_onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return (DW'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // ---------------- on-chip memory model ----------------
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [AW-1:0] ram_addr_q;
  assign mem_readdata = ram[ram_addr_q];

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      ram_addr_q <= mem_address;
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int   m_last = 1;   // master granted most recently
  int   m_run = 0;    // consecutive grants to m_last ending last cycle (0 after idle)
  logic m_acc0 = 1'b0;
  logic m_acc1 = 1'b0;

  function automatic int model_winner(input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (!r0 && r1) return 1;
`ifdef PROYECTO3_ONCHIP_ARB_RR_EN
    if (m_run > 0 && m_run < MAX_BURST_DEF) return m_last;
    return 1 - m_last;
`else
    return 0;
`endif
  endfunction

  int            cw;
  logic          cr0, cr1, cwr, crd;
  logic [AW-1:0] cad;
  logic [BW-1:0] cbe;
  logic [DW-1:0] cwd;

  // compare process: inputs are stable from posedge+1 through this negedge
  always @(negedge clk) begin
    if (reset) begin
      check("rst_rdv0", m0_readdatavalid, 0);
      check("rst_rdv1", m1_readdatavalid, 0);
      check("rst_cs", mem_chipselect, 0);
      check("rst_mem_write", mem_write, 0);
      exp_q0.delete();
      exp_q1.delete();
      m_last = 1;
      m_run = 0;
      m_acc0 = 1'b0;
      m_acc1 = 1'b0;
    end else begin
      check("rdv0", m0_readdatavalid, exp_q0.size() != 0);
      if (exp_q0.size() != 0) check("rdata0", m0_readdata, exp_q0.pop_front());
      check("rdv1", m1_readdatavalid, exp_q1.size() != 0);
      if (exp_q1.size() != 0) check("rdata1", m1_readdata, exp_q1.pop_front());

      cr0 = m0_read | m0_write;
      cr1 = m1_read | m1_write;
      cw = model_winner(cr0, cr1);
      check("wait0", m0_waitrequest, cr0 && (cw != 0));
      check("wait1", m1_waitrequest, cr1 && (cw != 1));
      check("chipselect", mem_chipselect, cw >= 0);
      check("clken", mem_clken, 1);
      m_acc0 = (cw == 0);
      m_acc1 = (cw == 1);

      if (cw < 0) begin
        check("idle_mem_write", mem_write, 0);
        m_run = 0;
      end else begin
        crd = (cw == 0) ? m0_read : m1_read;
        cwr = (cw == 0) ? m0_write : m1_write;
        cad = (cw == 0) ? m0_address : m1_address;
        cbe = (cw == 0) ? m0_byteenable : m1_byteenable;
        cwd = (cw == 0) ? m0_writedata : m1_writedata;
        check("mem_address", mem_address, cad);
        check("mem_byteenable", mem_byteenable, cbe);
        check("mem_writedata", mem_writedata, cwd);
        check("mem_write", mem_write, cwr);
        if (cwr) begin
          for (int b = 0; b < BW; b++) begin
            if (cbe[b]) ref_mem[cad][8*b +: 8] = cwd[8*b +: 8];
          end
        end else if (crd) begin
          if (cw == 0) exp_q0.push_back(ref_mem[cad]);
          else exp_q1.push_back(ref_mem[cad]);
        end
        if (cw == m_last) begin
          m_run++;
        end else begin
          m_last = cw;
          m_run = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [AW-1:0] ad,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = ad; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = ad; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  task automatic do_reset(input int cycles);
    idle_all();
    reset = 1;
    repeat (cycles) next_cyc();
    reset = 0;
  endtask

  task automatic rand_cmd(output logic rd, output logic wr, output logic [AW-1:0] ad,
                          output logic [BW-1:0] be, output logic [DW-1:0] wd);
    rd = 0;
    wr = 0;
    ad = AW'($urandom_range(0, 31));
    be = BW'($urandom_range(1, 15));
    wd = $urandom;
    if ($urandom_range(0, 9) < 7) begin
      if ($urandom_range(0, 2) == 0) wr = 1;
      else rd = 1;
    end
  endtask

  logic [DW-1:0] w;
  logic          exp_m0_wins;

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ram_addr_q = '0;
    m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    idle_all();
    reset = 1;
    repeat (3) next_cyc();
    reset = 0;

    // lone m0 read of 0x0010
    drive(0, 1, 0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk);
    check("t1_wait0", m0_waitrequest, 0);
    check("t1_addr", mem_address, 32'h0010);
    next_cyc();
    idle_all();
    @(negedge clk);
    check("t1_rdv0", m0_readdatavalid, 1);
    check("t1_rdata0", m0_readdata, init_word(32'h10));
    check("t1_rdv1", m1_readdatavalid, 0);
    next_cyc();

    // partial write by m0, read back by m1
    drive(0, 0, 1, 14'h0020, 4'b0011, 32'h12345678);
    @(negedge clk);
    check("t2_wait0", m0_waitrequest, 0);
    check("t2_mem_write", mem_write, 1);
    next_cyc();
    idle_all();
    drive(1, 1, 0, 14'h0020, 4'hF, 32'h0);
    next_cyc();
    idle_all();
    @(negedge clk);
    w = init_word(32'h20);
    check("t2_rdv1", m1_readdatavalid, 1);
    check("t2_rdata1", m1_readdata, {w[31:16], 16'h5678});
    next_cyc();

    // first tie after reset goes to m0; m1 waits exactly one cycle
    do_reset(2);
    drive(0, 1, 0, 14'h0030, 4'hF, 32'h0);
    drive(1, 1, 0, 14'h0040, 4'hF, 32'h0);
    @(negedge clk);
    check("t4_wait0", m0_waitrequest, 0);
    check("t4_wait1", m1_waitrequest, 1);
    next_cyc();
    m0_read = 0;
    @(negedge clk);
    check("t4_wait1_next", m1_waitrequest, 0);
    next_cyc();
    idle_all();
    next_cyc();

    // reset right after a granted read drops the response
    drive(1, 1, 0, 14'h0050, 4'hF, 32'h0);
    next_cyc();
    idle_all();
    reset = 1;
    @(negedge clk);
    check("t5_rdv0", m0_readdatavalid, 0);
    check("t5_rdv1", m1_readdatavalid, 0);
    next_cyc();
    reset = 0;
    drive(0, 1, 0, 14'h0060, 4'hF, 32'h0);
    drive(1, 1, 0, 14'h0070, 4'hF, 32'h0);
    @(negedge clk);
    check("t5_post_wait0", m0_waitrequest, 0);
    check("t5_post_wait1", m1_waitrequest, 1);
    next_cyc();
    m0_read = 0;
    next_cyc();
    idle_all();
    next_cyc();

    // continuous contention for 20 cycles
    do_reset(2);
    drive(0, 1, 0, 14'h0100, 4'hF, 32'h0);
    drive(1, 1, 0, 14'h0200, 4'hF, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifdef PROYECTO3_ONCHIP_ARB_RR_EN
      exp_m0_wins = ((i / MAX_BURST_DEF) % 2) == 0;
`else
      exp_m0_wins = 1'b1;
`endif
      check("t6_wait0", m0_waitrequest, !exp_m0_wins);
      check("t6_wait1", m1_waitrequest, exp_m0_wins);
      next_cyc();
    end
    idle_all();
    next_cyc();

    // randomized traffic with protocol-correct holds and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        idle_all();
        reset = 1;
        next_cyc();
        reset = 0;
      end else begin
        if (!((m0_read || m0_write) && !m_acc0))
          rand_cmd(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
        if (!((m1_read || m1_write) && !m_acc1))
          rand_cmd(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
        next_cyc();
      end
    end
    idle_all();
    repeat (2) next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
